// File: rtl/aes_encrypt_iter.sv
// ============================================================================
//  Module   : aes_encrypt_iter (with helper sbox)
//  Brief    : Iterative AES-128 encryptor, one round per clock, external keys.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        out_byte = sbox_f(in_byte);
    end
endmodule

module aes_encrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         pt_valid,
    output logic         pt_ready,
    input  logic [127:0] pt,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic [127:0] ct
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] C_LAST_RND = 4'd10;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] blk_q, blk_d;

    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic [127:0] w_round;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sbox
            sbox u_sbox (
                .in_byte  (blk_q[8*gi +: 8]),
                .out_byte (w_sb[8*gi +: 8])
            );
        end
    endgenerate

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte b = 4*col + row sits at bits [127-8b -: 8].
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = w_sr[127-32*c -: 8];
            a1 = w_sr[119-32*c -: 8];
            a2 = w_sr[111-32*c -: 8];
            a3 = w_sr[103-32*c -: 8];
            w_mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            w_mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            w_mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            w_mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
    end

    assign w_round = ((rnd_q == C_LAST_RND) ? w_sr : w_mc) ^ rk;

    always_comb begin
        fsm_d = fsm_q;
        rnd_d = rnd_q;
        blk_d = blk_q;
        case (fsm_q)
            S_IDLE: begin
                if (pt_valid) begin
                    blk_d = pt ^ rk;
                    rnd_d = 4'd1;
                    fsm_d = S_ROUND;
                end
            end
            S_ROUND: begin
                blk_d = w_round;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == C_LAST_RND) fsm_d = S_DONE;
            end
            S_DONE: begin
                if (ct_ready) begin
                    rnd_d = 4'd0;
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
                rnd_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= S_IDLE;
            rnd_q <= 4'd0;
            blk_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            rnd_q <= rnd_d;
            blk_q <= blk_d;
        end
    end

    // Outputs decode registered state only; no path from pt_valid/ct_ready.
    assign pt_ready = (fsm_q == S_IDLE);
    assign ct_valid = (fsm_q == S_DONE);
    assign rk_idx   = (fsm_q == S_ROUND) ? rnd_q : 4'd0;
    assign ct       = blk_q;
endmodule

`default_nettype wire

// File: tb/tb_aes_encrypt_iter.sv
// ============================================================================
//  Module   : tb_aes_encrypt_iter
//  Brief    : Scoreboard bench for aes_encrypt_iter using FIPS-197 vectors.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_encrypt_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         pt_valid;
    logic         pt_ready;
    logic [127:0] pt;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         ct_valid;
    logic         ct_ready;
    logic [127:0] ct;

    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic [127:0] rk_tbl [0:1][0:10];
    int           next_key;
    int           run_key;
    logic [127:0] sb [$];
    int           n_cmp = 0;
    int           n_bad = 0;

    aes_encrypt_iter dut (
        .clk      (clk),
        .rst      (rst),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt       (pt),
        .rk_idx   (rk_idx),
        .rk       (rk),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct       (ct)
    );

    always #5 clk = ~clk;

    // Key expansion stand-in: idle engine sees the key of the offered block.
    always_comb begin
        int idx;
        idx = (rk_idx > 4'd10) ? 0 : int'(rk_idx);
        rk  = pt_ready ? rk_tbl[next_key][idx] : rk_tbl[run_key][idx];
    end

    always @(posedge clk) begin
        if (!rst && pt_valid && pt_ready) run_key <= next_key;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_pt_ready"}, 128'(pt_ready), 128'd1);
        check({tag, "_ct_valid"}, 128'(ct_valid), 128'd0);
        check({tag, "_ct"},       ct,             128'd0);
        check({tag, "_rk_idx"},   128'(rk_idx),   128'd0);
    endtask

    task automatic offer(input int k, input logic [127:0] p);
        next_key = k;
        pt       = p;
        pt_valid = 1'b1;
    endtask

    task automatic wait_accept(input logic [127:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!pt_ready && n < 30) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", 128'(pt_ready), 128'd1);
        @(posedge clk);
        sb.push_back(exp);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 128'(sb.size()), 128'd0);
    endtask

    // Monitor: every ct handshake retires the oldest expected block.
    initial begin
        logic [127:0] exp;
        forever begin
            @(negedge clk);
            if (ct_valid && ct_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ct: got %h expected no output", ct);
                end else begin
                    exp = sb.pop_front();
                    check("ct", ct, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] held;
        int n;

        rk_tbl[0][0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_tbl[0][1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_tbl[0][2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_tbl[0][3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_tbl[0][4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_tbl[0][5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_tbl[0][6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_tbl[0][7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_tbl[0][8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_tbl[0][9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_tbl[0][10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        rk_tbl[1][0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tbl[1][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tbl[1][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tbl[1][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tbl[1][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tbl[1][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tbl[1][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tbl[1][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tbl[1][8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tbl[1][9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tbl[1][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        next_key = 0;
        run_key  = 0;
        rst      = 1'b1;
        pt_valid = 1'b0;
        pt       = '0;
        ct_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // C.1 vector: rk_idx sequence, latency, then backpressure in DONE.
        tick();
        offer(0, PT_C1);
        @(negedge clk);
        check("c1_rk_idx0", 128'(rk_idx), 128'd0);
        check("c1_pt_ready", 128'(pt_ready), 128'd1);
        @(posedge clk);
        sb.push_back(CT_C1);
        #1;
        pt_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("c1_rk_idx%0d", k), 128'(rk_idx), 128'(k));
            check($sformatf("c1_busy_ct_valid%0d", k), 128'(ct_valid), 128'd0);
            check($sformatf("c1_busy_pt_ready%0d", k), 128'(pt_ready), 128'd0);
        end
        @(negedge clk);
        check("c1_latency_ct_valid", 128'(ct_valid), 128'd1);
        held = ct;
        check("c1_ct_value", held, CT_C1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("bp_ct_valid%0d", i), 128'(ct_valid), 128'd1);
            check($sformatf("bp_ct_stable%0d", i), ct, held);
            check($sformatf("bp_pt_ready%0d", i), 128'(pt_ready), 128'd0);
        end
        tick();
        ct_ready = 1'b1;
        tick();
        ct_ready = 1'b0;
        @(negedge clk);
        check("bp_release_pt_ready", 128'(pt_ready), 128'd1);
        check("bp_release_ct_valid", 128'(ct_valid), 128'd0);
        check("bp_drain", 128'(sb.size()), 128'd0);

        // App.B vector with pt/pt_valid noise and ct_ready high while busy.
        tick();
        ct_ready = 1'b1;
        offer(1, PT_B);
        wait_accept(CT_B);
        for (int i = 0; i < 9; i++) begin
            pt_valid = 1'($urandom_range(0, 1));
            pt       = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        pt_valid = 1'b0;
        wait_drain("appb");

        // Reset at round 5 discards the block; a fresh block then completes.
        tick();
        offer(0, PT_C1);
        wait_accept(CT_C1);
        pt_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (rk_idx != 4'd5 && n < 12) begin
            n++;
            @(negedge clk);
        end
        check("mid_rst_reach_rnd5", 128'(rk_idx), 128'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check_reset_outputs("mid_rst");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("mid_rst_no_pulse%0d", i), 128'(ct_valid), 128'd0);
        end
        tick();
        offer(1, PT_B);
        wait_accept(CT_B);
        pt_valid = 1'b0;
        wait_drain("post_rst");

        // Back-to-back: second accept in the cycle right after the first ct handshake.
        tick();
        offer(0, PT_C1);
        wait_accept(CT_C1);
        next_key = 1;
        pt       = PT_B;
        n = 0;
        @(negedge clk);
        while (!ct_valid && n < 15) begin
            n++;
            @(negedge clk);
        end
        check("b2b_first_ct_valid", 128'(ct_valid), 128'd1);
        @(negedge clk);
        check("b2b_gap_pt_ready", 128'(pt_ready), 128'd1);
        @(posedge clk);
        sb.push_back(CT_B);
        #1;
        pt_valid = 1'b0;
        wait_drain("b2b");

        repeat (3) @(negedge clk);
        check("final_sb_empty", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
